// File: rtl/fp_exp_add_pipe.sv
// Exponent path of the floating-point multiplier: adds the biased exponents and the
// normalisation increment, removes the bias, classifies the result, all in a 2-stage valid/ready pipe.
module fp_exp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int BIAS  = 127,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic             norm_inc,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_out,
  output logic [TAG_W-1:0] tag_out,
  output logic [4:0]       flags
);

  localparam int SUM_W = EXP_W + 1;
  localparam int RES_W = EXP_W + 2;
  localparam logic [EXP_W-1:0]        EXP_ONES = '1;
  localparam logic signed [RES_W-1:0] BIAS_S   = RES_W'(BIAS);
  localparam logic signed [RES_W-1:0] OVF_TH   = RES_W'((2 ** EXP_W) - 1);

  // Flag bit positions inside {invalid, inf_nan, zero, ovf, unf}
  localparam int F_INVALID = 4;
  localparam int F_INF_NAN = 3;
  localparam int F_ZERO    = 2;
  localparam int F_OVF     = 1;
  localparam int F_UNF     = 0;

  logic             accept;
  logic             s2_adv;

  logic             s1_valid_reg;
  logic [SUM_W-1:0] s1_sum_reg;
  logic             s1_za_reg;
  logic             s1_zb_reg;
  logic             s1_ma_reg;
  logic             s1_mb_reg;
  logic [TAG_W-1:0] s1_tag_reg;

  logic [SUM_W-1:0] s1_sum_next;
  logic             s1_za_next;
  logic             s1_zb_next;
  logic             s1_ma_next;
  logic             s1_mb_next;

  logic             s2_valid_reg;
  logic [EXP_W-1:0] s2_exp_reg;
  logic [4:0]       s2_flags_reg;
  logic [TAG_W-1:0] s2_tag_reg;

  logic signed [RES_W-1:0] s2_res;
  logic [EXP_W-1:0]        s2_exp_next;
  logic [4:0]              s2_flags_next;

  // Handshake: S1 may refill whenever S2 is moving, so in_ready never looks at in_valid
  assign s2_adv   = !s2_valid_reg || out_ready;
  assign in_ready = !s1_valid_reg || s2_adv;
  assign accept   = in_valid && in_ready;

  // S1 datapath: carry is kept in the extra sum bit
  always_comb begin
    s1_sum_next = {1'b0, exp_a} + {1'b0, exp_b} + {{EXP_W{1'b0}}, norm_inc};
    s1_za_next  = (exp_a == '0);
    s1_zb_next  = (exp_b == '0);
    s1_ma_next  = (exp_a == EXP_ONES);
    s1_mb_next  = (exp_b == EXP_ONES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_sum_reg   <= '0;
      s1_za_reg    <= 1'b0;
      s1_zb_reg    <= 1'b0;
      s1_ma_reg    <= 1'b0;
      s1_mb_reg    <= 1'b0;
      s1_tag_reg   <= '0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      s1_sum_reg   <= s1_sum_next;
      s1_za_reg    <= s1_za_next;
      s1_zb_reg    <= s1_zb_next;
      s1_ma_reg    <= s1_ma_next;
      s1_mb_reg    <= s1_mb_next;
      s1_tag_reg   <= tag_in;
    end else if (s2_adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // S2 classification; the two extra result bits make the bias removal wrap-free
  always_comb begin
    s2_res        = $signed({1'b0, s1_sum_reg}) - BIAS_S;
    s2_exp_next   = '0;
    s2_flags_next = '0;
    if ((s1_za_reg && s1_mb_reg) || (s1_zb_reg && s1_ma_reg)) begin
      s2_flags_next[F_INVALID] = 1'b1;
      s2_exp_next              = EXP_ONES;
    end else if (s1_ma_reg || s1_mb_reg) begin
      s2_flags_next[F_INF_NAN] = 1'b1;
      s2_exp_next              = EXP_ONES;
    end else if (s1_za_reg || s1_zb_reg) begin
      s2_flags_next[F_ZERO] = 1'b1;
      s2_exp_next           = '0;
    end else if (s2_res >= OVF_TH) begin
      s2_flags_next[F_OVF] = 1'b1;
      s2_exp_next          = EXP_ONES;
    end else if (s2_res <= 0) begin
      s2_flags_next[F_UNF] = 1'b1;
      s2_exp_next          = '0;
    end else begin
      s2_exp_next = s2_res[EXP_W-1:0];
    end
  end

  // Outputs only reload when a new op moves in, so a stalled result holds steady
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_exp_reg   <= '0;
      s2_flags_reg <= '0;
      s2_tag_reg   <= '0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_exp_reg   <= s2_exp_next;
        s2_flags_reg <= s2_flags_next;
        s2_tag_reg   <= s1_tag_reg;
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign exp_out   = s2_exp_reg;
  assign flags     = s2_flags_reg;
  assign tag_out   = s2_tag_reg;

endmodule

// File: tb/tb_fp_exp_add_pipe.sv
// Directed bench for fp_exp_add_pipe (EXP_W=8, BIAS=127): vector table, backpressure stream, mid-flight reset.
module tb_fp_exp_add_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] exp_a;
  logic [7:0] exp_b;
  logic       norm_inc;
  logic [3:0] tag_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] exp_out;
  logic [3:0] tag_out;
  logic [4:0] flags;

  int checks = 0;
  int errors = 0;

  fp_exp_add_pipe #(.EXP_W(8), .BIAS(127), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .exp_a(exp_a), .exp_b(exp_b), .norm_inc(norm_inc), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .exp_out(exp_out), .tag_out(tag_out), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       inc;
    logic [3:0] tag;
    logic [7:0] exp_e;
    logic [4:0] flags_e;
  } vec_t;

  // {invalid, inf_nan, zero, ovf, unf}
  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_INV  = 5'b10000;
  localparam logic [4:0] F_INF  = 5'b01000;
  localparam logic [4:0] F_ZERO = 5'b00100;
  localparam logic [4:0] F_OVF  = 5'b00010;
  localparam logic [4:0] F_UNF  = 5'b00001;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Entered at posedge+1 with out_ready=1; checks latency is exactly 2 clocks
  task automatic run_vec(input vec_t v, input string nm);
    exp_a = v.a; exp_b = v.b; norm_inc = v.inc; tag_in = v.tag; in_valid = 1'b1;
    @(negedge clk);
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({nm, " out_valid@1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({nm, " out_valid@2"}, 32'(out_valid), 32'd1);
    chk({nm, " exp_out"}, 32'(exp_out), 32'(v.exp_e));
    chk({nm, " flags"}, 32'(flags), 32'(v.flags_e));
    chk({nm, " tag_out"}, 32'(tag_out), 32'(v.tag));
    $display("vec %s: a=%0d b=%0d inc=%0d -> exp_out=%0d flags=%b tag=%0d",
             nm, v.a, v.b, v.inc, exp_out, flags, tag_out);
  endtask

  initial begin
    vec_t v;
    int   rx;
    int   sent;
    bit   saw_stall_in;
    bit   held_ok;
    logic [7:0] h_exp;
    logic [3:0] h_tag;
    logic [4:0] h_flags;
    bit   prev_stall;

    vecs[0]  = '{8'd130, 8'd125, 1'b0, 4'd3,  8'd128, F_NONE};
    vecs[1]  = '{8'd200, 8'd200, 1'b0, 4'd1,  8'd255, F_OVF};
    vecs[2]  = '{8'd190, 8'd191, 1'b0, 4'd2,  8'd254, F_NONE};
    vecs[3]  = '{8'd190, 8'd191, 1'b1, 4'd4,  8'd255, F_OVF};
    vecs[4]  = '{8'd60,  8'd60,  1'b0, 4'd5,  8'd0,   F_UNF};
    vecs[5]  = '{8'd64,  8'd63,  1'b1, 4'd6,  8'd1,   F_NONE};
    vecs[6]  = '{8'd64,  8'd63,  1'b0, 4'd7,  8'd0,   F_UNF};
    vecs[7]  = '{8'd0,   8'd255, 1'b0, 4'd8,  8'd255, F_INV};
    vecs[8]  = '{8'd255, 8'd10,  1'b0, 4'd9,  8'd255, F_INF};
    vecs[9]  = '{8'd0,   8'd10,  1'b0, 4'd10, 8'd0,   F_ZERO};
    vecs[10] = '{8'd255, 8'd0,   1'b1, 4'd11, 8'd255, F_INV};
    vecs[11] = '{8'd255, 8'd255, 1'b0, 4'd12, 8'd255, F_INF};
    vecs[12] = '{8'd1,   8'd1,   1'b0, 4'd13, 8'd0,   F_UNF};
    vecs[13] = '{8'd254, 8'd254, 1'b1, 4'd14, 8'd255, F_OVF};
    vecs[14] = '{8'd127, 8'd127, 1'b0, 4'd15, 8'd127, F_NONE};
    vecs[15] = '{8'd10,  8'd0,   1'b1, 4'd0,  8'd0,   F_ZERO};

    rst_n = 1'b0; in_valid = 1'b0; exp_a = '0; exp_b = '0; norm_inc = 1'b0;
    tag_in = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst exp_out", 32'(exp_out), 32'd0);
    chk("rst tag_out", 32'(tag_out), 32'd0);
    chk("rst flags", 32'(flags), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("v%0d", i));
    @(posedge clk); #1;

    // Backpressure: tags 0..7, out_ready low for clocks 3..8 of the sequence
    rx = 0; sent = 0; saw_stall_in = 1'b0; held_ok = 1'b1; prev_stall = 1'b0;
    h_exp = '0; h_tag = '0; h_flags = '0;
    exp_b = 8'd127; norm_inc = 1'b0;
    fork
      begin
        for (int c = 1; c <= 12; c++) begin
          @(posedge clk); #1;
          out_ready = !(c >= 3 && c <= 8);
        end
        out_ready = 1'b1;
      end
      begin
        exp_a = 8'd100; tag_in = 4'd0; in_valid = 1'b1;
        for (int k = 0; k < 60 && sent < 8; k++) begin
          bit acc;
          @(negedge clk); acc = in_ready;
          if (!acc) saw_stall_in = 1'b1;
          @(posedge clk); #1;
          if (acc) begin
            sent++;
            if (sent < 8) begin
              exp_a = 8'(100 + sent); tag_in = 4'(sent);
            end else in_valid = 1'b0;
          end
        end
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 60 && rx < 8; k++) begin
          @(negedge clk);
          if (out_valid && !out_ready) begin
            if (prev_stall && (exp_out !== h_exp || tag_out !== h_tag || flags !== h_flags))
              held_ok = 1'b0;
            h_exp = exp_out; h_tag = tag_out; h_flags = flags; prev_stall = 1'b1;
          end else prev_stall = 1'b0;
          if (out_valid && out_ready) begin
            chk($sformatf("bp tag%0d", rx), 32'(tag_out), 32'(rx));
            chk($sformatf("bp exp%0d", rx), 32'(exp_out), 32'(100 + rx));
            $display("bp result: tag=%0d exp_out=%0d flags=%b", tag_out, exp_out, flags);
            rx++;
          end
        end
      end
    join
    chk("bp sent", 32'(sent), 32'd8);
    chk("bp received", 32'(rx), 32'd8);
    chk("bp in_ready dropped", 32'(saw_stall_in), 32'd1);
    chk("bp held stable", 32'(held_ok), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp no extra", 32'(out_valid), 32'd0);
    end

    // Reset with two ops in flight
    @(posedge clk); #1;
    out_ready = 1'b0; exp_a = 8'd130; exp_b = 8'd125; tag_in = 4'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    tag_in = 4'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst2 held valid", 32'(out_valid), 32'd1);
    chk("rst2 in_ready full", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2 out_valid async", 32'(out_valid), 32'd0);
    chk("rst2 tag_out async", 32'(tag_out), 32'd0);
    chk("rst2 exp_out async", 32'(exp_out), 32'd0);
    $display("async reset: out_valid=%0d", out_valid);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rst2 no stale", 32'(out_valid), 32'd0);
    end
    v = '{8'd130, 8'd125, 1'b0, 4'd9, 8'd128, F_NONE};
    run_vec(v, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
